// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller.
// Forward-select encodings, register-index width and the hard-wired zero register.
package hazard_fwd_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [REG_W-1:0] REG_X0 = '0;

    // EX/MEM is the younger producer, so it beats MEM/WB when both match.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex) begin
            return FWD_EXMEM;
        end else if (hit_mem) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hfc_sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
// Stops at all-ones instead of wrapping.
module hfc_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage core: shadow rd pipeline, registered forward
// selects, load-use stall, taken-branch flush and memory-busy freeze.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_W = hazard_fwd_ctrl_pkg::REG_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_tkn,
    input  logic             mem_busy,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import hazard_fwd_ctrl_pkg::*;

    localparam logic [REG_W-1:0] X0_IDX = REG_W'(REG_X0);

    logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic             ex_we_q, ex_we_d, ex_mr_q, ex_mr_d;
    logic             mem_we_q, mem_we_d, wb_we_q, wb_we_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    logic rs1_ex_match, rs2_ex_match, rs1_mem_match, rs2_mem_match;
    logic load_use, stall_inc, flush_inc;

    // Match terms exclude x0; ex_rd!=0 follows from rs!=0 and equality.
    always_comb begin
        rs1_ex_match  = id_use_rs1 && (id_rs1 != X0_IDX) && (ex_rd_q == id_rs1);
        rs2_ex_match  = id_use_rs2 && (id_rs2 != X0_IDX) && (ex_rd_q == id_rs2);
        rs1_mem_match = id_use_rs1 && (id_rs1 != X0_IDX) && (mem_rd_q == id_rs1);
        rs2_mem_match = id_use_rs2 && (id_rs2 != X0_IDX) && (mem_rd_q == id_rs2);
        load_use      = id_valid && ex_mr_q && (rs1_ex_match || rs2_ex_match);
        fwd_a_d       = fwd_pick(rs1_ex_match && ex_we_q, rs1_mem_match && mem_we_q);
        fwd_b_d       = fwd_pick(rs2_ex_match && ex_we_q, rs2_mem_match && mem_we_q);
    end

    // Priority: reset > freeze > taken branch > load-use > normal advance.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst_n) begin
            pc_we = 1'b1;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_branch_tkn) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_comb begin
        ex_rd_d  = id_rd;
        ex_we_d  = id_valid && id_regwrite && !idex_bubble;
        ex_mr_d  = id_valid && id_memread && !idex_bubble;
        mem_rd_d = ex_rd_q;
        mem_we_d = ex_we_q;
        wb_rd_d  = mem_rd_q;
        wb_we_d  = mem_we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_q  <= '0;
            ex_we_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_we_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_we_q  <= 1'b0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
        end else if (!mem_busy) begin
            ex_rd_q  <= ex_rd_d;
            ex_we_q  <= ex_we_d;
            ex_mr_q  <= ex_mr_d;
            mem_rd_q <= mem_rd_d;
            mem_we_q <= mem_we_d;
            wb_rd_q  <= wb_rd_d;
            wb_we_q  <= wb_we_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    // WB state is tracked for observability only; the register file covers WB->ID.
    logic unused_wb;
    assign unused_wb = ^{wb_rd_q, wb_we_q};

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

    hfc_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

    hfc_sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush_inc),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed pipeline scenarios plus random traffic
// against a queue-based pipeline model; a 2-bit-counter instance covers saturation.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_tkn, mem_busy;

    logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_s, fwd_b_s;
    logic        pc_we, ifid_we, idex_bubble, ifid_flush;
    logic        pc_we_s, ifid_we_s, idex_bubble_s, ifid_flush_s;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_tkn(ex_branch_tkn),
        .mem_busy(mem_busy), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_we(pc_we),
        .ifid_we(ifid_we), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_fwd_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_tkn(ex_branch_tkn),
        .mem_busy(mem_busy), .fwd_a_sel(fwd_a_s), .fwd_b_sel(fwd_b_s), .pc_we(pc_we_s),
        .ifid_we(ifid_we_s), .idex_bubble(idex_bubble_s), .ifid_flush(ifid_flush_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       mr;
    } slot_t;

    slot_t       pipe[$];
    logic [1:0]  m_fa, m_fb, m_sc_s, m_fc_s;
    logic [31:0] m_sc, m_fc;
    logic        e_pc, e_ifid, e_bub, e_flush, e_lu;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs, input logic use_rs);
        if (!use_rs || rs == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].we && pipe[k].rd == rs) return (k == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back(slot_t'(0));
        m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
    endtask

    task automatic model_eval();
        e_lu = id_valid && pipe[0].mr && pipe[0].rd != 5'd0 &&
               ((id_use_rs1 && pipe[0].rd == id_rs1) || (id_use_rs2 && pipe[0].rd == id_rs2));
        if (!rst_n)             {e_pc, e_ifid, e_bub, e_flush} = 4'b1100;
        else if (mem_busy)      {e_pc, e_ifid, e_bub, e_flush} = 4'b0000;
        else if (ex_branch_tkn) {e_pc, e_ifid, e_bub, e_flush} = 4'b1111;
        else if (e_lu)          {e_pc, e_ifid, e_bub, e_flush} = 4'b0010;
        else                    {e_pc, e_ifid, e_bub, e_flush} = 4'b1100;
    endtask

    task automatic tick();
        slot_t      s;
        logic [1:0] na, nb;
        logic       adv, br_ev, lu_ev;
        model_eval();
        adv   = rst_n && !mem_busy;
        s.rd  = id_rd;
        s.we  = id_valid && id_regwrite && !e_bub;
        s.mr  = id_valid && id_memread && !e_bub;
        na    = fwd_of(id_rs1, id_use_rs1);
        nb    = fwd_of(id_rs2, id_use_rs2);
        br_ev = ex_branch_tkn;
        lu_ev = e_lu && !ex_branch_tkn;
        @(posedge clk);
        if (adv) begin
            pipe.push_front(s);
            void'(pipe.pop_back());
            m_fa = na;
            m_fb = nb;
            if (br_ev) begin
                if (m_fc != 32'hFFFF_FFFF) m_fc++;
                if (m_fc_s != 2'b11) m_fc_s++;
            end else if (lu_ev) begin
                if (m_sc != 32'hFFFF_FFFF) m_sc++;
                if (m_sc_s != 2'b11) m_sc_s++;
            end
        end
        #1;
        model_eval();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ex_branch_tkn = 1'b0;
        mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_busy = 1'b1; ex_branch_tkn = 1'b0;
        set_id(1, 1, 1, 1, 1, 1, 1, 1);
        model_reset();
        #2;
        total++; if (pc_we !== 1'b1) begin bad++; $display("FAIL rst_pc_we: got %b want 1", pc_we); end
        total++; if (ifid_we !== 1'b1) begin bad++; $display("FAIL rst_ifid_we: got %b want 1", ifid_we); end
        total++; if ({idex_bubble, ifid_flush} !== 2'b00) begin bad++; $display("FAIL rst_bub_flush: got %b want 00", {idex_bubble, ifid_flush}); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL rst_sels: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
        total++; if ({stall_cnt, flush_cnt} !== 64'd0) begin bad++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        do_reset();
    endtask

    task automatic test_fwd_exmem();
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();   // add x5,x1,x2
        set_id(1, 5, 1, 1, 1, 6, 1, 0); tick();   // add x6,x5,x1
        total++; if (fwd_a_sel !== 2'b10) begin bad++; $display("FAIL t1_fwd_a: got %b want 10", fwd_a_sel); end
        total++; if (fwd_b_sel !== 2'b00) begin bad++; $display("FAIL t1_fwd_b: got %b want 00", fwd_b_sel); end
    endtask

    task automatic test_fwd_memwb();
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();   // add x5
        set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();   // nop
        set_id(1, 1, 5, 1, 1, 7, 1, 0); tick();   // sub x7,x1,x5
        total++; if (fwd_b_sel !== 2'b01) begin bad++; $display("FAIL t2_fwd_b: got %b want 01", fwd_b_sel); end
        total++; if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL t2_fwd_a: got %b want 00", fwd_a_sel); end
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
        set_id(1, 2, 1, 1, 1, 5, 1, 0); tick();
        set_id(1, 5, 5, 1, 1, 8, 1, 0); tick();
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin bad++; $display("FAIL t2_prio: got %b want 1010", {fwd_a_sel, fwd_b_sel}); end
    endtask

    task automatic test_load_use();
        logic [31:0] base;
        base = stall_cnt;
        set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();   // lw x5
        set_id(1, 5, 5, 1, 1, 6, 1, 0);           // add x6,x5,x5
        total++; if ({pc_we, ifid_we, idex_bubble} !== 3'b001) begin bad++; $display("FAIL t3_stall: got %b want 001", {pc_we, ifid_we, idex_bubble}); end
        tick();
        total++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) begin bad++; $display("FAIL t3_release: got %b want 110", {pc_we, ifid_we, idex_bubble}); end
        tick();
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin bad++; $display("FAIL t3_fwd: got %b want 0101", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_cnt !== base + 1) begin bad++; $display("FAIL t3_stall_cnt: got %0d want %0d", stall_cnt, base + 1); end
    endtask

    task automatic test_x0();
        set_id(1, 1, 0, 1, 0, 0, 1, 1); tick();   // lw x0
        set_id(1, 0, 0, 1, 1, 0, 1, 0);           // add x0,x0,x0
        total++; if ({pc_we, idex_bubble} !== 2'b10) begin bad++; $display("FAIL t4_nostall: got %b want 10", {pc_we, idex_bubble}); end
        tick();
        set_id(1, 0, 0, 1, 1, 9, 1, 0); tick();
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL t4_sels: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();   // lw x5
        ex_branch_tkn = 1'b1;
        set_id(1, 5, 0, 1, 0, 6, 1, 0);           // consumer would load-use
        total++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== 4'b1111) begin bad++; $display("FAIL t5_flush: got %b want 1111", {pc_we, ifid_we, idex_bubble, ifid_flush}); end
        tick();
        ex_branch_tkn = 1'b0;
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        total++; if ({idex_bubble, ifid_flush} !== 2'b00) begin bad++; $display("FAIL t5_after: got %b want 00", {idex_bubble, ifid_flush}); end
        total++; if ({flush_cnt, stall_cnt} !== {32'd1, 32'd0}) begin bad++; $display("FAIL t5_cnts: got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1, 2, 0, 1, 0, 1, 1, 0); tick();   // add x1
        set_id(1, 1, 2, 1, 1, 5, 1, 1); tick();   // lw x5,(x1)
        mem_busy = 1'b1;
        set_id(1, 1, 5, 1, 1, 6, 1, 0);           // add x6,x1,x5
        for (int i = 0; i < 3; i++) begin
            total++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== 4'b0000) begin bad++; $display("FAIL t6_frz_ctl%0d: got %b want 0000", i, {pc_we, ifid_we, idex_bubble, ifid_flush}); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin bad++; $display("FAIL t6_frz_sel%0d: got %b want 1000", i, {fwd_a_sel, fwd_b_sel}); end
            total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL t6_frz_cnt%0d: got %0d want 0", i, stall_cnt); end
            tick();
        end
        mem_busy = 1'b0;
        #1; model_eval();
        total++; if ({pc_we, idex_bubble} !== 2'b01) begin bad++; $display("FAIL t6_post_stall: got %b want 01", {pc_we, idex_bubble}); end
        tick();
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL t6_stall_cnt: got %0d want 1", stall_cnt); end
        tick();
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin bad++; $display("FAIL t6_fwd: got %b want 0001", {fwd_a_sel, fwd_b_sel}); end
        set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();   // lw x5
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        total++; if (idex_bubble !== 1'b1) begin bad++; $display("FAIL t6_restall: got %b want 1", idex_bubble); end
        rst_n = 1'b0;
        #1;
        total++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== 4'b1100) begin bad++; $display("FAIL t6_rst_ctl: got %b want 1100", {pc_we, ifid_we, idex_bubble, ifid_flush}); end
        total++; if ({stall_cnt, flush_cnt} !== 64'd0) begin bad++; $display("FAIL t6_rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL t6_rst_sel: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mem_busy      = ($urandom_range(0, 9) == 0);
            ex_branch_tkn = ($urandom_range(0, 9) == 0);
            set_id(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 2) == 0));
            total++; if ({pc_we, ifid_we, idex_bubble, ifid_flush} !== {e_pc, e_ifid, e_bub, e_flush}) begin bad++; $display("FAIL rnd_ctl@%0d: got %b want %b", i, {pc_we, ifid_we, idex_bubble, ifid_flush}, {e_pc, e_ifid, e_bub, e_flush}); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== {m_fa, m_fb}) begin bad++; $display("FAIL rnd_sel@%0d: got %b want %b", i, {fwd_a_sel, fwd_b_sel}, {m_fa, m_fb}); end
            total++; if ({stall_cnt, flush_cnt} !== {m_sc, m_fc}) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_sc, m_fc); end
            total++; if ({stall_cnt_s, flush_cnt_s} !== {m_sc_s, m_fc_s}) begin bad++; $display("FAIL rnd_sat@%0d: got %b want %b", i, {stall_cnt_s, flush_cnt_s}, {m_sc_s, m_fc_s}); end
            tick();
        end
        total++; if ({stall_cnt_s, flush_cnt_s} !== 4'b1111) begin bad++; $display("FAIL rnd_saturated: got %b want 1111", {stall_cnt_s, flush_cnt_s}); end
        mem_busy = 1'b0; ex_branch_tkn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_load_use();
        test_x0();
        test_branch();
        test_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
